// File: rtl/btn_pkg.sv
// Shared constants for the button event block: debouncer input codes, event codes and FSM states.
package btn_pkg;

    localparam logic [1:0] SW_IDLE  = 2'b11;
    localparam logic [1:0] SW_SHORT = 2'b10;
    localparam logic [1:0] SW_LONG  = 2'b01;
    localparam logic [1:0] SW_HELD  = 2'b00;

    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_HOLD   = 2'b11;
    localparam logic [1:0] EV_REPEAT = 2'b00;

    localparam int REP_W = 29;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/btn_event_slot.sv
// One-entry valid/ready event holding register with a sticky overflow flag.
module btn_event_slot
    import btn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] load_code,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] code,
    output logic       ovf
);

    // A new event is accepted if the slot is empty or draining this edge; otherwise it is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            code  <= 2'b00;
            ovf   <= 1'b0;
        end else if (load) begin
            if (!valid || ready) begin
                valid <= 1'b1;
                code  <= load_code;
            end else begin
                ovf <= 1'b1;
            end
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/btn_event.sv
// Turns debouncer state codes into short/long/hold/repeat events; auto-repeat is built only
// when BTN_EVENT_AUTOREPEAT_EN is defined.
module btn_event
    import btn_pkg::*;
#(
    parameter int unsigned DIV_CONST  = 50_000_000,
    parameter int unsigned REPEAT_DIV = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_sw_state,
    output logic       o_ev_valid,
    output logic [1:0] o_ev_code,
    input  logic       i_ev_ready,
    output logic       o_hold,
    output logic       o_ovf
);

    if (DIV_CONST / REPEAT_DIV < 2) begin : g_bad_period
        $error("btn_event: DIV_CONST/REPEAT_DIV must be at least 2");
    end

    state_e     state, state_d;
    logic [1:0] s_q;
    logic       held_lock;
    logic       entry;
    logic       ev_load;
    logic [1:0] ev_code;

`ifdef BTN_EVENT_AUTOREPEAT_EN
    localparam logic [REP_W-1:0] RELOAD = REP_W'(DIV_CONST / REPEAT_DIV - 1);
    logic [REP_W-1:0] rep_cnt, rep_d;
`endif

    assign entry = (s_q != i_sw_state);

    always_comb begin
        state_d = state;
        ev_load = 1'b0;
        ev_code = EV_SHORT;
`ifdef BTN_EVENT_AUTOREPEAT_EN
        rep_d   = rep_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (entry) begin
                    case (i_sw_state)
                        SW_SHORT: begin
                            ev_load = 1'b1;
                            ev_code = EV_SHORT;
                        end
                        SW_LONG: begin
                            ev_load = 1'b1;
                            ev_code = EV_LONG;
                        end
                        SW_HELD: begin
                            if (!held_lock) begin
                                ev_load = 1'b1;
                                ev_code = EV_HOLD;
                                state_d = ST_HOLD;
`ifdef BTN_EVENT_AUTOREPEAT_EN
                                rep_d   = RELOAD;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_HOLD: begin
                // Leaving hold swallows whatever release code the debouncer reports.
                if (i_sw_state != SW_HELD) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef BTN_EVENT_AUTOREPEAT_EN
                    if (rep_cnt == '0) begin
                        ev_load = 1'b1;
                        ev_code = EV_REPEAT;
                        rep_d   = RELOAD;
                    end else begin
                        rep_d = rep_cnt - 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // held_lock stops a button still held through reset from posing as a fresh hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            s_q       <= SW_IDLE;
            held_lock <= (i_sw_state == SW_HELD);
        end else begin
            state     <= state_d;
            s_q       <= i_sw_state;
            held_lock <= held_lock && (i_sw_state == SW_HELD);
        end
    end

`ifdef BTN_EVENT_AUTOREPEAT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_d;
        end
    end
`endif

    assign o_hold = (state == ST_HOLD);

    btn_event_slot u_slot (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (ev_load),
        .load_code (ev_code),
        .ready     (i_ev_ready),
        .valid     (o_ev_valid),
        .code      (o_ev_code),
        .ovf       (o_ovf)
    );

endmodule

// File: tb/tb_btn_event.sv
// Directed self-checking bench for btn_event at DIV_CONST=80, REPEAT_DIV=8 (10-cycle repeat).
module tb_btn_event;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw_state;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_ready;
    logic       hold;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    btn_event #(
        .DIV_CONST  (80),
        .REPEAT_DIV (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw_state (sw_state),
        .o_ev_valid (ev_valid),
        .o_ev_code  (ev_code),
        .i_ev_ready (ev_ready),
        .o_hold     (hold),
        .o_ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs are sampled and inputs changed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        sw_state = 2'b11;
        ev_ready = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({ev_valid, ev_code, hold, ovf} !== 5'b0_00_0_0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000", {ev_valid, ev_code, hold, ovf});
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({ev_valid, hold, ovf} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL post_reset_idle: got %b expected 000", {ev_valid, hold, ovf});
        end
    endtask

    task automatic test_short();
        sw_state = 2'b10;
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL short_event: got valid=%b code=%b expected valid=1 code=01", ev_valid, ev_code);
        end
        sw_state = 2'b11;
        step();
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL short_one_cycle: got valid=%b expected 0", ev_valid);
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL short_ovf: got %b expected 0", ovf);
        end
    endtask

    task automatic test_hold_repeat();
        logic       exp_valid;
        logic [1:0] exp_code;
        ev_ready = 1'b1;
        sw_state = 2'b00;
        for (int c = 1; c <= 35; c++) begin
            step();
            exp_valid = (c == 1);
            exp_code  = 2'b11;
`ifdef BTN_EVENT_AUTOREPEAT_EN
            if (c == 11 || c == 21 || c == 31) begin
                exp_valid = 1'b1;
                exp_code  = 2'b00;
            end
`endif
            n_cmp++;
            if (ev_valid !== exp_valid) begin
                n_err++;
                $display("[TB] FAIL hold_valid c=%0d: got %b expected %b", c, ev_valid, exp_valid);
            end
            if (exp_valid) begin
                n_cmp++;
                if (ev_code !== exp_code) begin
                    n_err++;
                    $display("[TB] FAIL hold_code c=%0d: got %b expected %b", c, ev_code, exp_code);
                end
            end
            n_cmp++;
            if (hold !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL hold_level c=%0d: got %b expected 1", c, hold);
            end
        end
        sw_state = 2'b10;
        step();
        n_cmp++;
        if ({ev_valid, hold} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL hold_exit: got valid,hold=%b expected 00", {ev_valid, hold});
        end
        sw_state = 2'b11;
        step();
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL hold_exit_quiet: got valid=%b expected 0", ev_valid);
        end
    endtask

    task automatic test_overflow();
        ev_ready = 1'b0;
        sw_state = 2'b10;
        step();
        sw_state = 2'b11;
        repeat (4) step();
        sw_state = 2'b01;
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL ovf_old_kept: got valid=%b code=%b expected valid=1 code=01", ev_valid, ev_code);
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL ovf_set: got %b expected 1", ovf);
        end
        sw_state = 2'b11;
        ev_ready = 1'b1;
        step();
        n_cmp++;
        if (ev_valid !== 1'b0 || ovf !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL ovf_sticky: got valid=%b ovf=%b expected valid=0 ovf=1", ev_valid, ovf);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL ovf_reset_clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        ev_ready = 1'b0;
        sw_state = 2'b10;
        step();
        sw_state = 2'b11;
        step();
        ev_ready = 1'b1;
        sw_state = 2'b01;
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b10 || ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_replace: got valid=%b code=%b ovf=%b expected 1 10 0", ev_valid, ev_code, ovf);
        end
        sw_state = 2'b11;
        step();
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_drain: got valid=%b expected 0", ev_valid);
        end
    endtask

    task automatic test_reset_in_hold();
        ev_ready = 1'b0;
        sw_state = 2'b00;
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b11 || hold !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rh_enter: got valid=%b code=%b hold=%b expected 1 11 1", ev_valid, ev_code, hold);
        end
        step();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({ev_valid, ev_code, hold, ovf} !== 5'b0_00_0_0) begin
            n_err++;
            $display("[TB] FAIL rh_reset: got %b expected 00000", {ev_valid, ev_code, hold, ovf});
        end
        rst_n    = 1'b1;
        ev_ready = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            n_cmp++;
            if (ev_valid !== 1'b0 || hold !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL rh_quiet c=%0d: got valid=%b hold=%b expected 0 0", c, ev_valid, hold);
            end
        end
        sw_state = 2'b11;
        step();
        sw_state = 2'b00;
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_code !== 2'b11 || hold !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rh_reenter: got valid=%b code=%b hold=%b expected 1 11 1", ev_valid, ev_code, hold);
        end
        sw_state = 2'b11;
        step();
        n_cmp++;
        if (hold !== 1'b0 || ev_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rh_release: got hold=%b valid=%b expected 0 0", hold, ev_valid);
        end
    endtask

    initial begin
        $display("[TB] btn_event directed test start");
        test_reset();
        test_short();
        test_hold_repeat();
        test_overflow();
        test_back_to_back();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 SHALL have parameter DIV_CONST, default 50_000_000, system clock cycles per second (same meaning as in the debouncer).
REQ-002 SHALL have parameter REPEAT_DIV, default 8, auto-repeat rate in repeats per second; repeat period = DIV_CONST/REPEAT_DIV cycles.
REQ-003 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_sw_state  input  2  debouncer code: 11 idle/pressing, 10 short release, 01 long release, 00 held past timeout.
REQ-006 SHALL have port o_ev_valid  output  1  event pending.
REQ-007 SHALL have port o_ev_code  output  2  event: 01 short, 10 long, 11 hold-start, 00 repeat; meaningful only while o_ev_valid=1.
REQ-008 SHALL have port i_ev_ready  input  1  consumer accepts the pending event.
REQ-009 SHALL have port o_hold  output  1  level; high while the button is in the held state.
REQ-010 SHALL have port o_ovf  output  1  sticky; set when an event is lost.

Function
REQ-011 SHALL register i_sw_state once (s_q) and detect entry into a code as s_q != i_sw_state.
REQ-012 SHALL use a two-state FSM: IDLE and HOLD.
REQ-013 In IDLE, entry into 10 SHALL raise event 01; entry into 01 SHALL raise event 10.
REQ-014 In IDLE, entry into 00 SHALL raise event 11, move to HOLD, set o_hold, and load the repeat counter with DIV_CONST/REPEAT_DIV-1.
REQ-015 In HOLD, the repeat counter SHALL decrement each cycle; at 0 it SHALL raise event 00 and reload.
REQ-016 In HOLD, i_sw_state != 00 SHALL return to IDLE and clear o_hold in the same edge, with no event for that cycle; a release code (10/01) seen on exit SHALL be ignored.
REQ-017 Any input code persisting more than one cycle SHALL raise at most one event (entry only).
REQ-018 A raised event SHALL appear on o_ev_valid/o_ev_code on the next clock edge (latency 1 cycle from the input change).
REQ-019 The event register SHALL be one entry: the transfer completes on a cycle with o_ev_valid & i_ev_ready, after which o_ev_valid drops unless a new event is loaded the same edge.
REQ-020 A new event on a cycle when the register is occupied and i_ev_ready=0 SHALL be dropped, the old event SHALL be kept, and o_ovf SHALL be set.
REQ-021 A new event on the same cycle as an accepted transfer SHALL replace the register, keep o_ev_valid=1, and not set o_ovf.
REQ-022 o_ev_code SHALL be held stable while o_ev_valid=1 and i_ev_ready=0.
REQ-023 o_ovf SHALL clear only on reset.
REQ-024 The repeat counter SHALL be 29 bits wide, unsigned; DIV_CONST/REPEAT_DIV SHALL be computed at elaboration and be at least 2.

Reset
REQ-025 i_rst_n=0 at an edge SHALL force: FSM IDLE, s_q=11, o_ev_valid=0, o_ev_code=00, o_hold=0, o_ovf=0, repeat counter 0.
REQ-026 Reset during HOLD or with an event pending SHALL discard the event; after release, an input already at 00 SHALL not raise an event until it leaves and re-enters 00.

Configuration
REQ-027 With macro BTN_EVENT_AUTOREPEAT_EN defined, HOLD SHALL generate repeat events per REQ-015.
REQ-028 Without BTN_EVENT_AUTOREPEAT_EN, the repeat counter SHALL not be built, HOLD SHALL emit no 00 events, and all other behaviour SHALL be unchanged.

Structure
REQ-029 The shared package btn_pkg SHALL hold the input-code constants (SW_IDLE, SW_SHORT, SW_LONG, SW_HELD), the event-code constants (EV_SHORT, EV_LONG, EV_HOLD, EV_REPEAT), and the FSM state enum.
REQ-030 The one-entry valid/ready holding register SHALL be the sub-module btn_event_slot; the FSM and counter SHALL stay in btn_event.

Verification (DIV_CONST=80, REPEAT_DIV=8: repeat period 10 cycles)
REQ-031 11->10 for 1 cycle, ready=1 -> one cycle later o_ev_valid=1 for exactly 1 cycle with code 01; o_ovf=0.
REQ-032 11->00 held 35 cycles, ready=1 -> code 11 at +1, code 00 at +11, +21 and +31; o_hold high 35 cycles.
REQ-033 Short release with ready=0, then long release 5 cycles later -> code 01 is held, the long event is dropped, o_ovf=1 until reset.
REQ-034 Event pending, ready=1, with a new long release on the same cycle -> o_ev_valid stays 1, code becomes 10, o_ovf=0.
REQ-035 In HOLD, rst_n=0 for 1 cycle while the input stays 00 -> all outputs are at reset values and no event occurs until 00 is re-entered.
REQ-036 The REQ-032 stimulus built without BTN_EVENT_AUTOREPEAT_EN -> only code 11 is produced; o_hold is unchanged.
